// File: rtl/ysyx_23060303_ifu.sv
// Instruction fetch unit of the NPC core.
// Holds the PC and keeps at most one instruction-memory read outstanding.
// The returned word is registered and offered to decode with a valid/ready
// handshake. Execute may redirect the PC in any state. A redirect that arrives
// while a read is still in flight marks that read as killed, so its response
// is dropped when it returns.
module ysyx_23060303_ifu #(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32'h8000_0000)
) (
  input  logic              clk,
  input  logic              rst,
  // instruction memory request / response
  output logic              imem_req_valid,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_req_ready,
  input  logic              imem_resp_valid,
  input  logic [INST_W-1:0] imem_resp_data,
  input  logic              imem_resp_err,
  // decode side
  output logic              inst_valid,
  output logic [INST_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_fault,
  input  logic              inst_ready,
  // redirect from execute
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_OUT  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              kill_q, kill_d;
  logic [INST_W-1:0] inst_data_q, inst_data_d;
  logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
  logic              inst_fault_q, inst_fault_d;

  logic              misaligned;
  logic              req_fire;

  assign misaligned = (pc_q[1:0] != 2'b00);
  assign req_fire   = imem_req_valid && imem_req_ready;

  // State register and fetched-instruction registers (asynchronous reset)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      kill_q       <= 1'b0;
      inst_data_q  <= '0;
      inst_pc_q    <= RESET_PC;
      inst_fault_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      kill_q       <= kill_d;
      inst_data_q  <= inst_data_d;
      inst_pc_q    <= inst_pc_d;
      inst_fault_q <= inst_fault_d;
    end
  end

  // Next-state logic: redirect wins in every state and always loads the PC
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    kill_d       = kill_q;
    inst_data_d  = inst_data_q;
    inst_pc_d    = inst_pc_q;
    inst_fault_d = inst_fault_q;
    unique case (state_q)
      S_REQ: begin
        if (redirect_valid) begin
          pc_d = redirect_pc;
        end else if (misaligned) begin
          // Misaligned PC never reaches memory; report a fault instead.
          state_d      = S_OUT;
          inst_data_d  = '0;
          inst_fault_d = 1'b1;
          inst_pc_d    = pc_q;
        end else if (req_fire) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          pc_d = redirect_pc;
          if (imem_resp_valid) begin
            // Response for the old PC lands this very cycle: drop it now.
            state_d = S_REQ;
            kill_d  = 1'b0;
          end else begin
            // Read still in flight: remember to discard it on return.
            kill_d = 1'b1;
          end
        end else if (imem_resp_valid) begin
          if (kill_q) begin
            state_d = S_REQ;
            kill_d  = 1'b0;
          end else begin
            state_d      = S_OUT;
            inst_data_d  = imem_resp_data;
            inst_fault_d = imem_resp_err;
            inst_pc_d    = pc_q;
          end
        end
      end
      S_OUT: begin
        if (redirect_valid) begin
          // Any concurrent handshake is consumed, but the PC follows execute.
          pc_d    = redirect_pc;
          state_d = S_REQ;
        end else if (inst_ready) begin
          pc_d    = pc_q + ADDR_W'(4);
          state_d = S_REQ;
        end
      end
      default: begin
        state_d = S_REQ;
      end
    endcase
  end

  // Output logic: request only from REQ with an aligned PC and no redirect
  always_comb begin
    imem_req_valid = !rst && (state_q == S_REQ) && !redirect_valid && !misaligned;
    imem_req_addr  = pc_q;
    inst_valid     = (state_q == S_OUT);
    inst_data      = inst_data_q;
    inst_pc        = inst_pc_q;
    inst_fault     = inst_fault_q;
  end

endmodule

// File: tb/tb_ysyx_23060303_ifu.sv
// Directed bench for the fetch unit. A small memory model answers each
// accepted request with ~addr after a programmable number of cycles.
module tb_ysyx_23060303_ifu;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        imem_resp_err;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_fault;
  logic        inst_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int checks = 0;
  int errors = 0;

  // memory model state
  int          resp_delay = 1;
  logic        err_next   = 1'b0;
  logic        pend       = 1'b0;
  int          cnt        = 0;
  logic [31:0] paddr      = '0;
  logic        hs;

  ysyx_23060303_ifu #(
    .ADDR_W  (32),
    .INST_W  (32),
    .RESET_PC(32'h8000_0000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .imem_resp_err  (imem_resp_err),
    .inst_valid     (inst_valid),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .inst_fault     (inst_fault),
    .inst_ready     (inst_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", tag, act, exp);
    end
  endtask

  // One clock: sample the request handshake mid-cycle, then advance the
  // memory model just after the edge.
  task automatic step();
    @(negedge clk);
    hs = imem_req_valid && imem_req_ready;
    @(posedge clk);
    #1;
    imem_resp_valid = 1'b0;
    imem_resp_err   = 1'b0;
    if (hs) begin
      pend  = 1'b1;
      cnt   = resp_delay;
      paddr = imem_req_addr;
    end
    if (pend) begin
      cnt--;
      if (cnt == 0) begin
        pend            = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data  = ~paddr;
        imem_resp_err   = err_next;
      end
    end
    #1;
  endtask

  initial begin
    rst             = 1'b1;
    imem_req_ready  = 1'b1;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    imem_resp_err   = 1'b0;
    inst_ready      = 1'b1;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;

    // reset state
    step();
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_req_addr", imem_req_addr, 32'h8000_0000);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst_data", inst_data, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h8000_0000);
    chk("rst_inst_fault", 32'(inst_fault), 32'd0);
    rst = 1'b0;
    #1;

    // streaming fetch, one request every 3 cycles
    chk("f0_req_valid", 32'(imem_req_valid), 32'd1);
    chk("f0_req_addr", imem_req_addr, 32'h8000_0000);
    step();
    chk("f0_wait_valid", 32'(inst_valid), 32'd0);
    chk("f0_wait_req", 32'(imem_req_valid), 32'd0);
    step();
    chk("f0_out_valid", 32'(inst_valid), 32'd1);
    chk("f0_out_data", inst_data, 32'h7FFF_FFFF);
    chk("f0_out_pc", inst_pc, 32'h8000_0000);
    chk("f0_out_fault", 32'(inst_fault), 32'd0);
    step();
    chk("f1_req_addr", imem_req_addr, 32'h8000_0004);
    chk("f1_req_valid", 32'(imem_req_valid), 32'd1);
    step();
    step();
    chk("f1_out_data", inst_data, 32'h7FFF_FFFB);
    chk("f1_out_pc", inst_pc, 32'h8000_0004);

    // decode back-pressure for 5 cycles
    inst_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_valid", 32'(inst_valid), 32'd1);
      chk("stall_data", inst_data, 32'h7FFF_FFFB);
      chk("stall_pc", inst_pc, 32'h8000_0004);
      chk("stall_no_req", 32'(imem_req_valid), 32'd0);
    end
    inst_ready = 1'b1;
    step();
    chk("f2_req_addr", imem_req_addr, 32'h8000_0008);
    chk("f2_inst_valid", 32'(inst_valid), 32'd0);

    // memory not ready for 3 cycles, then a 4-cycle response
    imem_req_ready = 1'b0;
    resp_delay     = 4;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mstall_req_valid", 32'(imem_req_valid), 32'd1);
      chk("mstall_req_addr", imem_req_addr, 32'h8000_0008);
    end
    imem_req_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("mslow_wait_valid", 32'(inst_valid), 32'd0);
    end
    step();
    chk("mslow_out_valid", 32'(inst_valid), 32'd1);
    chk("mslow_out_data", inst_data, 32'h7FFF_FFF7);
    chk("mslow_out_pc", inst_pc, 32'h8000_0008);
    resp_delay = 1;
    step();
    chk("f3_req_addr", imem_req_addr, 32'h8000_000C);
    step();
    step();
    chk("f3_out_data", inst_data, 32'h7FFF_FFF3);
    step();
    chk("f4_req_addr", imem_req_addr, 32'h8000_0010);

    // redirect one cycle after the request is accepted: response killed
    resp_delay = 3;
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0100;
    #1;
    chk("kill_wait_req", 32'(imem_req_valid), 32'd0);
    step();
    redirect_valid = 1'b0;
    #1;
    chk("kill_wait_valid", 32'(inst_valid), 32'd0);
    chk("kill_wait_req2", 32'(imem_req_valid), 32'd0);
    step();
    chk("kill_resp_valid", 32'(inst_valid), 32'd0);
    step();
    chk("kill_drop_valid", 32'(inst_valid), 32'd0);
    chk("kill_next_req", 32'(imem_req_valid), 32'd1);
    chk("kill_next_addr", imem_req_addr, 32'h8000_0100);
    resp_delay = 1;
    step();
    step();
    chk("redir_out_data", inst_data, 32'h7FFF_FEFF);
    chk("redir_out_pc", inst_pc, 32'h8000_0100);
    step();
    chk("redir_next_addr", imem_req_addr, 32'h8000_0104);

    // redirect coincident with the response in WAIT
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0200;
    step();
    redirect_valid = 1'b0;
    #1;
    chk("coresp_valid", 32'(inst_valid), 32'd0);
    chk("coresp_req", 32'(imem_req_valid), 32'd1);
    chk("coresp_addr", imem_req_addr, 32'h8000_0200);
    step();
    step();
    chk("coresp_out_valid", 32'(inst_valid), 32'd1);
    chk("coresp_out_data", inst_data, 32'h7FFF_FDFF);
    chk("coresp_out_pc", inst_pc, 32'h8000_0200);

    // redirect coincident with inst_ready in OUT
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0300;
    step();
    redirect_valid = 1'b0;
    #1;
    chk("coout_valid", 32'(inst_valid), 32'd0);
    chk("coout_addr", imem_req_addr, 32'h8000_0300);

    // misaligned redirect target
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0102;
    #1;
    chk("mis_redir_req", 32'(imem_req_valid), 32'd0);
    step();
    redirect_valid = 1'b0;
    #1;
    chk("mis_req_valid", 32'(imem_req_valid), 32'd0);
    chk("mis_req_inst", 32'(inst_valid), 32'd0);
    step();
    chk("mis_out_valid", 32'(inst_valid), 32'd1);
    chk("mis_out_fault", 32'(inst_fault), 32'd1);
    chk("mis_out_data", inst_data, 32'h0);
    chk("mis_out_pc", inst_pc, 32'h8000_0102);
    chk("mis_out_req", 32'(imem_req_valid), 32'd0);
    inst_ready     = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0104;
    step();
    redirect_valid = 1'b0;
    inst_ready     = 1'b1;
    #1;
    chk("mis_recover_addr", imem_req_addr, 32'h8000_0104);
    chk("mis_recover_req", 32'(imem_req_valid), 32'd1);

    // bus error on the response
    err_next = 1'b1;
    step();
    step();
    err_next = 1'b0;
    chk("err_out_valid", 32'(inst_valid), 32'd1);
    chk("err_out_fault", 32'(inst_fault), 32'd1);
    chk("err_out_data", inst_data, 32'h7FFF_FEFB);
    chk("err_out_pc", inst_pc, 32'h8000_0104);
    step();
    chk("err_next_addr", imem_req_addr, 32'h8000_0108);
    chk("err_next_fault", 32'(inst_valid), 32'd0);

    // reset pulsed during WAIT; the stale response must be ignored
    resp_delay = 3;
    step();
    rst = 1'b1;
    #1;
    chk("rstw_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rstw_addr", imem_req_addr, 32'h8000_0000);
    chk("rstw_inst_valid", 32'(inst_valid), 32'd0);
    imem_req_ready = 1'b0;
    step();
    rst = 1'b0;
    step();
    chk("stale_resp_seen", 32'(imem_resp_valid), 32'd1);
    chk("stale_inst_valid", 32'(inst_valid), 32'd0);
    chk("stale_req_addr", imem_req_addr, 32'h8000_0000);
    step();
    chk("stale_after_valid", 32'(inst_valid), 32'd0);
    chk("stale_after_req", 32'(imem_req_valid), 32'd1);
    imem_req_ready = 1'b1;
    resp_delay     = 1;
    step();
    step();
    chk("post_rst_data", inst_data, 32'h7FFF_FFFF);
    chk("post_rst_pc", inst_pc, 32'h8000_0000);
    step();

    // back-to-back redirects in REQ: last target wins
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0400;
    step();
    redirect_pc    = 32'h8000_0500;
    step();
    redirect_valid = 1'b0;
    #1;
    chk("b2b_addr", imem_req_addr, 32'h8000_0500);

    // PC wraps to zero past the top of the address space
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    step();
    step();
    chk("wrap_out_data", inst_data, 32'h0000_0003);
    chk("wrap_out_pc", inst_pc, 32'hFFFF_FFFC);
    step();
    chk("wrap_next_addr", imem_req_addr, 32'h0000_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_23060303_ifu.md
Name: ysyx_23060303_ifu

Overview:
Instruction fetch stage of the NPC core. Holds the PC and issues one read at a time to instruction memory over a valid/ready request channel. Registers the returned word and presents it, with its PC, to the decode stage through a valid/ready handshake. Decode slices opcode/funct3/funct7 from inst_data as keys for its key-to-data lookup tables. Accepts branch/jump redirects from execute, including while a fetch is in flight.

Parameters:
ADDR_W, 32, width of PC and memory address
INST_W, 32, instruction word width
RESET_PC, 32'h8000_0000, PC loaded on reset

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
imem_req_valid  out  1  fetch request valid
imem_req_addr  out  ADDR_W  fetch address (= pc)
imem_req_ready  in  1  memory accepts request
imem_resp_valid  in  1  response data valid (single-cycle pulse)
imem_resp_data  in  INST_W  fetched word
imem_resp_err  in  1  access fault for this response
inst_valid  out  1  instruction available to decode
inst_data  out  INST_W  instruction word
inst_pc  out  ADDR_W  PC of inst_data
inst_fault  out  1  fetch fault (bus error or misaligned PC)
inst_ready  in  1  decode accepts instruction
redirect_valid  in  1  redirect request from execute
redirect_pc  in  ADDR_W  redirect target

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high, ports clk and rst.
- Reset values: state=REQ, pc=RESET_PC, kill=0, inst_valid=0, inst_data=0, inst_pc=RESET_PC, inst_fault=0. imem_req_valid is forced 0 while rst=1.
- FSM states: REQ, WAIT, OUT. imem_req_valid = (state==REQ) && !redirect_valid && (pc[1:0]==0). imem_req_addr = pc. inst_valid = (state==OUT).
- REQ:
  - If pc[1:0]!=0: no memory request. Next cycle OUT with inst_data=0, inst_fault=1, inst_pc=pc.
  - Else on imem_req_valid && imem_req_ready: go to WAIT.
  - imem_req_addr is held stable while waiting for ready.
- WAIT:
  - On imem_resp_valid with kill=0: capture inst_data=resp_data, inst_fault=resp_err, inst_pc=pc; go to OUT.
  - On imem_resp_valid with kill=1: drop the response, clear kill, go to REQ.
  - imem_resp_valid is ignored in REQ and OUT.
- OUT:
  - inst_* are held stable while inst_valid && !inst_ready.
  - On inst_ready: pc=pc+4 (mod 2^ADDR_W, wraps to 0), go to REQ.
- Redirect has priority in every state; pc is loaded with redirect_pc that cycle.
  - REQ: request suppressed that cycle; stay REQ.
  - WAIT: set kill; stay WAIT until the response returns, then drop it.
  - WAIT, same cycle as resp_valid: response dropped, go to REQ, kill stays 0.
  - OUT: go to REQ. inst_valid falls next cycle. If inst_ready was also high, the handshake still counts as consumed, but pc=redirect_pc, not pc+4.
  - Back-to-back redirects: last target wins.
- Latency (zero-wait memory): request accepted at cycle n, response at n+1, inst_valid at n+2. With inst_ready=1, the next request is at n+3. Steady throughput is 1 instruction per 3 cycles.
- Reset mid-operation: everything returns to reset values immediately. Any later response from the old transaction arrives in REQ and is ignored.
- At most one outstanding memory request; no prefetch buffer.

Test Plan:
- Reset release, memory always ready with 1-cycle response, inst_ready=1 -> requests to 0x80000000, 0x80000004, 0x80000008, one every 3 cycles; inst_pc/inst_data match the memory model.
- inst_ready held 0 for 5 cycles in OUT -> inst_valid, inst_data, inst_pc unchanged; no new imem request; pc advances by 4 only after the handshake.
- Memory imem_req_ready low 3 cycles, then response delayed 4 cycles -> imem_req_addr stable during the stall; single response captured.
- redirect_valid to 0x80000100 one cycle after a request to 0x80000010 is accepted -> the 0x80000010 response is dropped (inst_valid stays 0); next request is to 0x80000100.
- Redirect coincident with resp_valid in WAIT, and coincident with inst_ready in OUT -> response dropped / instruction consumed; next fetch is at redirect_pc.
- redirect_pc=0x80000102 -> no imem request; inst_valid with inst_fault=1, inst_data=0, inst_pc=0x80000102. Separately, imem_resp_err=1 -> inst_fault=1. Also, rst pulsed while in WAIT -> pc=0x80000000 and the stale response is ignored.
